// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter.
// Grants are sticky while the owner keeps requesting. A hold counter lets
// another waiting requester preempt the owner after HOLD_MAX cycles.
// All outputs come straight from flops, so there is no combinational
// path from req to gnt.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  // 2-to-4 one-hot decode of an owner index
  function automatic logic [3:0] dec2(input logic [1:0] idx);
    dec2 = 4'b0001 << idx;
  endfunction

  // First set bit of r, searching upward from start and wrapping 3 -> 0
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] cand;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (r[cand]) begin
        pick = cand;
      end else begin
        pick = pick;
      end
    end
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       others_s;
  logic [1:0]       win_s;

  // Next-state logic: arbitration points, hold counting and release handling
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    win_s    = 2'd0;
    others_s = req & ~dec2(idx_q);
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          win_s   = pick(req, last_q + 2'd1);
          state_d = GRANT;
          idx_d   = win_s;
          last_d  = win_s;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        // Owner released, or held too long while someone else waits
        if (!req[idx_q] || ((cnt_q == HOLD_LAST) && (others_s != 4'b0000))) begin
          if (others_s != 4'b0000) begin
            // The owner is excluded, so the search effectively starts at owner+1
            win_s   = pick(others_s, idx_q + 2'd1);
            idx_d   = win_s;
            last_d  = win_s;
            cnt_d   = '0;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else begin
          valid_d = 1'b1;
          if (cnt_q != HOLD_LAST) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    gnt_d = valid_d ? dec2(idx_d) : 4'b0000;
  end

  // State and output registers; last starts at 3 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule
